// File: rtl/exc_sequencer.sv
// exc_sequencer: commit-point exception/interrupt/ERET sequencer at the MEM stage.
// Latency: EXL strobe, ExcCode, EPC and flush in the trigger cycle; pc_redirect FLUSH_CYCLES+1 cycles later.
// Backpressure: none; while busy, all triggers are ignored and the pipeline is held flushed.
// Optional build macro EXC_STATS_EN adds a saturating 16-bit exl_set counter output (exc_count).

module exc_sequencer #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic        exl,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic        m_exc,
  input  logic [4:0]  m_exc_code,
  input  logic        m_eret,
  input  logic [31:0] cp0_epc,
  output logic        exl_set,
  output logic        exl_clr,
  output logic [4:0]  exc_code_o,
  output logic [31:0] epc_o,
  output logic        bd_o,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
`ifdef EXC_STATS_EN
  ,
  output logic [15:0] exc_count
`endif
);

  // Sequencer states
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  // Counter preload: FLUSH exits when the counter reads zero, so N-1 gives N FLUSH cycles
  localparam logic [2:0] LP_CNT_INIT = 3'(FLUSH_CYCLES - 1);

  // State and datapath registers
  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic        r_pend;
  logic [31:0] r_target;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;
  logic        r_bd;

  // Trigger decode and derived values
  logic        w_idle;
  logic        w_take_int;
  logic        w_take_exc;
  logic        w_take_eret;
  logic        w_take_trap;
  logic        w_take_any;
  logic [31:0] w_epc_new;
  logic [4:0]  w_code_new;

  // Current SR.EXL does not change sequencing: exl_set is pulsed even for
  // nested exceptions and CP0 itself decides whether to update EPC/Cause.
  // The pending-interrupt latch is tracked state only; the take condition
  // re-samples int_req every cycle, so a dropped request is never taken.
  logic        w_unused_sig;
  assign w_unused_sig = exl ^ r_pend;

  assign w_idle = (r_state == ST_IDLE);

  // Priority int_req > m_exc > m_eret; bubbles never trigger anything, and an
  // interrupt waiting for a real instruction blocks lower-priority triggers.
  assign w_take_int  = w_idle & ~reset & int_req & m_valid;
  assign w_take_exc  = w_idle & ~reset & ~int_req & m_valid & m_exc;
  assign w_take_eret = w_idle & ~reset & ~int_req & m_valid & ~m_exc & m_eret;
  assign w_take_trap = w_take_int | w_take_exc;
  assign w_take_any  = w_take_trap | w_take_eret;

  // A delay-slot instruction restarts at its branch; subtraction wraps mod 2^32
  assign w_epc_new  = m_bd ? (m_pc - 32'd4) : m_pc;
  assign w_code_new = w_take_int ? 5'd0 : m_exc_code;

  // Strobes and redirect are pure decode; reset suppresses them in its own cycle
  assign exl_set     = w_take_trap;
  assign exl_clr     = w_take_eret;
  assign flush       = ~reset & (w_take_any | ~w_idle);
  assign pc_redirect = ~reset & (r_state == ST_REDIRECT);
  assign redirect_pc = pc_redirect ? r_target : 32'd0;
  assign busy        = ~w_idle;

  // CP0 fields present the new values in the strobe cycle, otherwise hold
  assign exc_code_o = w_take_trap ? w_code_new : r_exc_code;
  assign epc_o      = w_take_trap ? w_epc_new  : r_epc;
  assign bd_o       = w_take_trap ? m_bd       : r_bd;

  // Main FSM: IDLE -> FLUSH (counted) -> REDIRECT -> IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      r_target <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take_any) begin
            r_state  <= ST_FLUSH;
            r_cnt    <= LP_CNT_INIT;
            r_target <= w_take_eret ? cp0_epc : HANDLER_ADDR;
          end
        end
        ST_FLUSH: begin
          if (r_cnt == 3'd0) begin
            r_state <= ST_REDIRECT;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_REDIRECT: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pending-interrupt latch: set while the interrupt waits for a real
  // instruction, dropped when int_req falls or when any sequence starts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= 1'b0;
    end else if (w_take_any) begin
      r_pend <= 1'b0;
    end else if (w_idle) begin
      if (int_req & ~m_valid) begin
        r_pend <= 1'b1;
      end else if (~int_req) begin
        r_pend <= 1'b0;
      end
    end
  end

  // Hold registers for the CP0 Cause/EPC fields, captured on each exl_set
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exc_code <= 5'd0;
      r_epc      <= 32'd0;
      r_bd       <= 1'b0;
    end else if (w_take_trap) begin
      r_exc_code <= w_code_new;
      r_epc      <= w_epc_new;
      r_bd       <= m_bd;
    end
  end

`ifdef EXC_STATS_EN
  logic [15:0] r_exc_count;

  // Saturating count of exception/interrupt entries
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exc_count <= 16'd0;
    end else if (w_take_trap && (r_exc_count != 16'hFFFF)) begin
      r_exc_count <= r_exc_count + 16'd1;
    end
  end

  assign exc_count = r_exc_count;
`endif

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: each step drives inputs just after the
// rising edge and checks outputs at the following falling edge.
module tb_exc_sequencer;

  localparam int          FC      = 2;
  localparam logic [31:0] HANDLER = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        int_req, exl, m_valid, m_bd, m_exc, m_eret;
  logic [31:0] m_pc, cp0_epc;
  logic [4:0]  m_exc_code;
  logic        exl_set, exl_clr, bd_o, flush, pc_redirect, busy;
  logic [4:0]  exc_code_o;
  logic [31:0] epc_o, redirect_pc;
`ifdef EXC_STATS_EN
  logic [15:0] exc_count;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  exc_sequencer #(.HANDLER_ADDR(HANDLER), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .int_req(int_req), .exl(exl), .m_valid(m_valid),
    .m_pc(m_pc), .m_bd(m_bd), .m_exc(m_exc), .m_exc_code(m_exc_code),
    .m_eret(m_eret), .cp0_epc(cp0_epc), .exl_set(exl_set), .exl_clr(exl_clr),
    .exc_code_o(exc_code_o), .epc_o(epc_o), .bd_o(bd_o), .flush(flush),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .busy(busy)
`ifdef EXC_STATS_EN
    , .exc_count(exc_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    int_req = 1'b0; exl = 1'b0; m_valid = 1'b0; m_bd = 1'b0;
    m_exc = 1'b0; m_eret = 1'b0; m_pc = 32'd0; m_exc_code = 5'd0;
  endtask

  // advance to just after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called at the falling edge of the trigger cycle. Walks FLUSH and REDIRECT,
  // optionally hammering every trigger during FLUSH, then checks the return to IDLE.
  task automatic run_seq(input string tag, input logic [31:0] tgt,
                         input logic noisy, input logic [4:0] held_code);
    for (int k = 1; k <= FC; k++) begin
      next_cycle();
      clear_inputs();
      if (noisy) begin
        int_req = 1'b1; m_valid = 1'b1; m_exc = 1'b1; m_eret = 1'b1;
        m_exc_code = 5'd7; m_pc = 32'h0000_5000; cp0_epc = 32'h0000_6000;
      end
      @(negedge clk);
      chk({tag, "_flush_f"}, flush, 1);
      chk({tag, "_busy_f"}, busy, 1);
      chk({tag, "_redir_f"}, pc_redirect, 0);
      chk({tag, "_set_f"}, exl_set, 0);
      chk({tag, "_clr_f"}, exl_clr, 0);
      chk({tag, "_code_hold"}, exc_code_o, held_code);
    end
    next_cycle();
    clear_inputs();
    cp0_epc = 32'd0;
    @(negedge clk);
    chk({tag, "_redir"}, pc_redirect, 1);
    chk({tag, "_tgt"}, redirect_pc, tgt);
    chk({tag, "_flush_r"}, flush, 1);
    chk({tag, "_busy_r"}, busy, 1);
    next_cycle();
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_flush"}, flush, 0);
    chk({tag, "_idle_redir"}, pc_redirect, 0);
  endtask

  initial begin
    clear_inputs();
    cp0_epc = 32'd0;
    reset   = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_flush", flush, 0);
    chk("rst_set", exl_set, 0);
    chk("rst_clr", exl_clr, 0);
    chk("rst_redir", pc_redirect, 0);
    chk("rst_epc", epc_o, 0);
    chk("rst_code", exc_code_o, 0);
    chk("rst_bd", bd_o, 0);
`ifdef EXC_STATS_EN
    chk("rst_count", exc_count, 0);
`endif

    // exception, code 12, not in a delay slot
    next_cycle();
    m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd12; m_pc = 32'h0000_3010;
    @(negedge clk);
    chk("exc_set", exl_set, 1);
    chk("exc_clr", exl_clr, 0);
    chk("exc_epc", epc_o, 32'h0000_3010);
    chk("exc_code", exc_code_o, 12);
    chk("exc_bd", bd_o, 0);
    chk("exc_flush", flush, 1);
    chk("exc_redir", pc_redirect, 0);
    run_seq("exc", HANDLER, 1'b0, 5'd12);
    chk("exc_epc_hold", epc_o, 32'h0000_3010);

    // interrupt from a delay slot
    next_cycle();
    int_req = 1'b1; m_valid = 1'b1; m_bd = 1'b1; m_pc = 32'h0000_3024;
    @(negedge clk);
    chk("int_set", exl_set, 1);
    chk("int_epc", epc_o, 32'h0000_3020);
    chk("int_bd", bd_o, 1);
    chk("int_code", exc_code_o, 0);
    run_seq("int", HANDLER, 1'b0, 5'd0);

    // interrupt waits two bubble cycles for a real instruction
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      int_req = 1'b1; m_valid = 1'b0; m_pc = 32'h0000_3038;
      @(negedge clk);
      chk("pend_set", exl_set, 0);
      chk("pend_flush", flush, 0);
      chk("pend_busy", busy, 0);
    end
    next_cycle();
    int_req = 1'b1; m_valid = 1'b1; m_bd = 1'b0; m_pc = 32'h0000_3040;
    @(negedge clk);
    chk("pend_take", exl_set, 1);
    chk("pend_epc", epc_o, 32'h0000_3040);
    chk("pend_bd", bd_o, 0);
    run_seq("pend", HANDLER, 1'b0, 5'd0);

    // interrupt drops while pending: nothing is taken
    next_cycle();
    int_req = 1'b1; m_valid = 1'b0;
    @(negedge clk);
    chk("drop_wait", exl_set, 0);
    next_cycle();
    int_req = 1'b0; m_valid = 1'b1; m_pc = 32'h0000_3044;
    @(negedge clk);
    chk("drop_set", exl_set, 0);
    chk("drop_flush", flush, 0);

    // ERET back to EPC; CP0 fields keep their previous values
    next_cycle();
    clear_inputs();
    m_valid = 1'b1; m_eret = 1'b1; cp0_epc = 32'h0000_3048; m_pc = 32'h0000_3100;
    @(negedge clk);
    chk("eret_clr", exl_clr, 1);
    chk("eret_set", exl_set, 0);
    chk("eret_flush", flush, 1);
    chk("eret_epc_hold", epc_o, 32'h0000_3040);
    run_seq("eret", 32'h0000_3048, 1'b0, 5'd0);

    // interrupt beats a simultaneous exception; triggers during FLUSH ignored
    next_cycle();
    int_req = 1'b1; m_exc = 1'b1; m_exc_code = 5'd12; m_valid = 1'b1;
    m_pc = 32'h0000_3050; m_eret = 1'b1;
    @(negedge clk);
    chk("prio_set", exl_set, 1);
    chk("prio_clr", exl_clr, 0);
    chk("prio_code", exc_code_o, 0);
    chk("prio_epc", epc_o, 32'h0000_3050);
    run_seq("prio", HANDLER, 1'b1, 5'd0);

    // delay-slot EPC wraps below zero; exl=1 still pulses exl_set
    next_cycle();
    clear_inputs();
    exl = 1'b1; m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd4; m_bd = 1'b1; m_pc = 32'd0;
    @(negedge clk);
    chk("wrap_set", exl_set, 1);
    chk("wrap_epc", epc_o, 32'hFFFF_FFFC);
    chk("wrap_code", exc_code_o, 4);

    // reset in the first FLUSH cycle aborts the sequence
    next_cycle();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    chk("rmid_redir", pc_redirect, 0);
    chk("rmid_flush", flush, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rmid_busy", busy, 0);
    chk("rmid_code", exc_code_o, 0);
    for (int k = 0; k < FC + 2; k++) begin
      chk("rmid_noredir", pc_redirect, 0);
      next_cycle();
      @(negedge clk);
    end
    chk("rmid_end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
